// File: rtl/rand_word_gen_pkg.sv
// Shared constants and types for the random word generator: default Galois
// tap masks per LFSR width, the default seed and the draw FSM encoding.
package rand_pkg;

    localparam logic [7:0]  TAPS_W8           = 8'hB8;
    localparam logic [15:0] TAPS_W16          = 16'hB400;
    localparam logic [23:0] TAPS_W24          = 24'hE10000;
    localparam logic [31:0] TAPS_W32          = 32'hA3000000;
    localparam logic [31:0] RAND_SEED_DEFAULT = 32'h0000_0001;

    typedef enum logic {
        SHIFT = 1'b0,
        VALID = 1'b1
    } fsm_t;

    function automatic logic [31:0] default_taps(input int w);
        case (w)
            8:       return {24'h0, TAPS_W8};
            16:      return {16'h0, TAPS_W16};
            24:      return {8'h0, TAPS_W24};
            32:      return TAPS_W32;
            default: return {16'h0, TAPS_W16};
        endcase
    endfunction

endpackage

// File: rtl/rand_word_gen_lfsr_step.sv
// Galois LFSR core: holds the W-bit state, advances one step on request and
// accepts a parallel load that takes priority over stepping.
module lfsr_step
    import rand_pkg::*;
#(
    parameter int           W            = 16,
    parameter logic [W-1:0] TAPS         = W'(default_taps(W)),
    parameter logic [W-1:0] SEED_DEFAULT = W'(RAND_SEED_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state,
    output logic         out_bit
);

    logic [W-1:0] r_state;
    logic [W-1:0] w_next;

    always_comb begin
        w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SEED_DEFAULT;
        end else if (load) begin
            r_state <= load_val;
        end else if (step) begin
            r_state <= w_next;
        end
    end

    assign state   = r_state;
    assign out_bit = r_state[0];

endmodule

// File: rtl/rand_word_gen.sv
// K-bit random words from a Galois LFSR over a valid/ready handshake, with seed
// load and zero-state recovery. Define RAND_NO_REPEAT_EN to suppress repeats.
module rand_word_gen
    import rand_pkg::*;
#(
    parameter int           W            = 16,
    parameter int           K            = 2,
    parameter logic [W-1:0] TAPS         = W'(default_taps(W)),
    parameter logic [W-1:0] SEED_DEFAULT = W'(RAND_SEED_DEFAULT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         seed_load,
    input  logic [W-1:0] seed_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] rand_val,
    output logic         lockup
);

    localparam int CW = $clog2(K + 1);

    fsm_t         r_fsm;
    fsm_t         w_fsm_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [K-1:0] r_v;
    logic [K-1:0] w_v_next;
    logic [K:0]   w_cat;
    logic [K-1:0] r_rand;
    logic         r_valid;
    logic         r_lockup;
    logic [W-1:0] w_state;
    logic         w_bit;
    logic         w_step;
    logic         w_load;
    logic [W-1:0] w_load_val;
    logic         w_done;
    logic         w_accept;
    logic         w_lock_set;
    logic         w_repeat;

`ifdef RAND_NO_REPEAT_EN
    logic [K-1:0] r_last;

    always_comb begin
        w_repeat = (w_v_next == r_last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= '0;
        end else if (seed_load) begin
            r_last <= '0;
        end else if (w_accept) begin
            r_last <= r_rand;
        end
    end
`else
    always_comb begin
        w_repeat = 1'b0;
    end
`endif

    lfsr_step #(
        .W            (W),
        .TAPS         (TAPS),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (w_step),
        .load     (w_load),
        .load_val (w_load_val),
        .state    (w_state),
        .out_bit  (w_bit)
    );

    // New bit enters at the LSB, so the first bit of a word ends up in the MSB.
    always_comb begin
        w_cat    = {r_v, w_bit};
        w_v_next = w_cat[K-1:0];
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_cnt_next = r_cnt;
        w_step     = 1'b0;
        w_load     = 1'b0;
        w_load_val = SEED_DEFAULT;
        w_done     = 1'b0;
        w_accept   = 1'b0;
        w_lock_set = 1'b0;
        if (seed_load) begin
            w_load     = 1'b1;
            w_load_val = (seed_in == '0) ? SEED_DEFAULT : seed_in;
            w_fsm_next = SHIFT;
            w_cnt_next = '0;
        end else begin
            case (r_fsm)
                SHIFT: begin
                    if (w_state == '0) begin
                        w_load     = 1'b1;
                        w_lock_set = 1'b1;
                        w_cnt_next = '0;
                    end else begin
                        w_step = 1'b1;
                        if (r_cnt == CW'(K - 1)) begin
                            if (w_repeat) begin
                                w_cnt_next = '0;
                            end else begin
                                w_cnt_next = CW'(K);
                                w_done     = 1'b1;
                                w_fsm_next = VALID;
                            end
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
                VALID: begin
                    if (r_valid && out_ready) begin
                        w_accept   = 1'b1;
                        w_fsm_next = SHIFT;
                        w_cnt_next = '0;
                    end
                end
                default: begin
                    w_fsm_next = SHIFT;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm    <= SHIFT;
            r_cnt    <= '0;
            r_v      <= '0;
            r_rand   <= '0;
            r_valid  <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_fsm    <= w_fsm_next;
            r_cnt    <= w_cnt_next;
            r_lockup <= w_lock_set;
            r_valid  <= (w_fsm_next == VALID);
            if (w_step) begin
                r_v <= w_v_next;
            end
            if (w_done) begin
                r_rand <= w_v_next;
            end
        end
    end

    assign out_valid = r_valid;
    assign rand_val  = r_rand;
    assign lockup    = r_lockup;

endmodule
